// File: rtl/dmem_responder.sv
// Data-memory responder for a simple CPU: word-addressed RAM, one GPIO output
// register and a free-running cycle counter. Each request gets one response
// after a fixed number of wait states.
//
// Handshake: a request (read or write high) is accepted only on a rising edge
// while the FSM is in IDLE. Address, data and kind are frozen at that edge.
// ready pulses for exactly one cycle in RESP, and err rides along with it.
// Requests seen in WAIT or RESP are dropped, not queued. The CPU must keep the
// request high until an IDLE edge if it wants it taken.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] gpio_out,
  output logic [1:0]  fsm_state
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] GPIO_ADDR = 32'hFFFF_FF00;
  localparam logic [31:0] CNT_ADDR  = 32'hFFFF_FF04;
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  // Debug encoding on fsm_state: IDLE=0, WAIT=1, RESP=2.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  wait_cnt;
  logic        req_rd;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_err;
  logic [31:0] cycle_cnt;
  logic [31:0] ram [DEPTH];

  logic        cur_rd;
  logic        cur_wr;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        is_ram;
  logic        is_gpio;
  logic        is_cnt;
  logic        illegal;
  logic [31:0] rd_val;
  logic        enter_resp;

  // Request seen by the response logic. With no wait states, RESP is entered
  // on the accept edge itself, so the live inputs are used in IDLE.
  always_comb begin
    cur_rd    = req_rd;
    cur_wr    = req_wr;
    cur_addr  = req_addr;
    cur_wdata = req_wdata;
    if (state == IDLE) begin
      cur_rd    = read;
      cur_wr    = write;
      cur_addr  = address;
      cur_wdata = wdata;
    end
    is_ram  = (cur_addr < 32'(DEPTH));
    is_gpio = (cur_addr == GPIO_ADDR);
    is_cnt  = (cur_addr == CNT_ADDR);
    illegal = (cur_rd && cur_wr) || !(is_ram || is_gpio || is_cnt) || (cur_wr && is_cnt);
    rd_val  = '0;
    if (is_ram) begin
      rd_val = ram[cur_addr[AW-1:0]];
    end else if (is_gpio) begin
      rd_val = gpio_out;
    end else if (is_cnt) begin
      rd_val = cycle_cnt;
    end
  end

  // FSM next state and the one-cycle ready/err pulse.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE: if (read || write) state_nx = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: if (wait_cnt == 3'd0) state_nx = RESP;
      RESP: begin
        state_nx = IDLE;
        ready    = 1'b1;
        err      = req_err;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Gating with rst keeps the reset-less RAM from writing while reset is held.
  assign enter_resp = rst && (state != RESP) && (state_nx == RESP);
  assign fsm_state  = state;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Capture the request at acceptance and count down the wait states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      wait_cnt  <= 3'd0;
    end else if (state == IDLE) begin
      if (read || write) begin
        req_rd    <= read;
        req_wr    <= write;
        req_addr  <= address;
        req_wdata <= wdata;
        wait_cnt  <= WAIT_LOAD;
      end
    end else if ((state == WAIT) && (wait_cnt != 3'd0)) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // Response capture: read data, error flag and GPIO commit on entry to RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata    <= '0;
      req_err  <= 1'b0;
      gpio_out <= '0;
    end else if (enter_resp) begin
      req_err <= illegal;
      rdata   <= (illegal || !cur_rd) ? 32'd0 : rd_val;
      if (!illegal && cur_wr && is_gpio) gpio_out <= cur_wdata;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (enter_resp && !illegal && cur_wr && is_ram) ram[cur_addr[AW-1:0]] <= cur_wdata;
  end

  // Free-running cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycle_cnt <= '0;
    else      cycle_cnt <= cycle_cnt + 32'd1;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (1, 0 and 3 wait states) driven one
// at a time, checked against a transaction-level model of memory, GPIO and the
// cycle counter.
module tb_dmem_responder;

  localparam int          NDUT   = 3;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] GPIO_A = 32'hFFFF_FF00;
  localparam logic [31:0] CNT_A  = 32'hFFFF_FF04;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_i    [NDUT];
  logic        wr_i    [NDUT];
  logic [31:0] addr_i  [NDUT];
  logic [31:0] wd_i    [NDUT];
  logic [31:0] rdata_o [NDUT];
  logic        ready_o [NDUT];
  logic        err_o   [NDUT];
  logic [31:0] gpio_o  [NDUT];
  logic [1:0]  st_o    [NDUT];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] ref_cyc   [NDUT];
  logic [31:0] ref_gpio  [NDUT];
  logic [31:0] ref_ram   [NDUT][DEPTH];
  bit          ref_known [NDUT][DEPTH];
  logic [31:0] exp_q[$];

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .read(rd_i[0]), .write(wr_i[0]), .address(addr_i[0]),
    .wdata(wd_i[0]), .rdata(rdata_o[0]), .ready(ready_o[0]), .err(err_o[0]),
    .gpio_out(gpio_o[0]), .fsm_state(st_o[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .read(rd_i[1]), .write(wr_i[1]), .address(addr_i[1]),
    .wdata(wd_i[1]), .rdata(rdata_o[1]), .ready(ready_o[1]), .err(err_o[1]),
    .gpio_out(gpio_o[1]), .fsm_state(st_o[1])
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .read(rd_i[2]), .write(wr_i[2]), .address(addr_i[2]),
    .wdata(wd_i[2]), .rdata(rdata_o[2]), .ready(ready_o[2]), .err(err_o[2]),
    .gpio_out(gpio_o[2]), .fsm_state(st_o[2])
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // One clock: rising edge (model counters advance), then back to the falling edge.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (rst) ref_cyc[d] = ref_cyc[d] + 32'd1;
      else     ref_cyc[d] = 32'd0;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < NDUT; d++) begin
      rd_i[d]   = 1'b0;
      wr_i[d]   = 1'b0;
      addr_i[d] = '0;
      wd_i[d]   = '0;
    end
  endtask

  // Assert reset at a falling edge, check outputs, hold two cycles, release.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    for (int d = 0; d < NDUT; d++) begin
      ref_cyc[d]  = '0;
      ref_gpio[d] = '0;
    end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_ready_%0d", d), 32'(ready_o[d]), 32'd0);
      check($sformatf("rst_err_%0d", d), 32'(err_o[d]), 32'd0);
      check($sformatf("rst_rdata_%0d", d), rdata_o[d], 32'd0);
      check($sformatf("rst_gpio_%0d", d), gpio_o[d], 32'd0);
      check($sformatf("rst_state_idle_%0d", d), 32'(st_o[d]), 32'd0);
    end
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One full transaction on instance d, called at a falling edge with the DUT idle.
  // hold=1 presents a different request throughout WAIT/RESP, which must be ignored.
  task automatic do_req(input int d, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, input string tag);
    int          ws;
    bit          is_ram, is_gpio, is_cnt, illegal, chk_rd;
    logic [31:0] gpio_before, gpio_after;
    ws          = ws_of(d);
    is_ram      = (a < 32'(DEPTH));
    is_gpio     = (a == GPIO_A);
    is_cnt      = (a == CNT_A);
    illegal     = (rd && wr) || !(is_ram || is_gpio || is_cnt) || (wr && is_cnt);
    gpio_before = ref_gpio[d];
    gpio_after  = gpio_before;
    chk_rd      = 1'b0;
    if (illegal) begin
      exp_q.push_back(32'd0);
      chk_rd = 1'b1;
    end else if (rd) begin
      if (is_gpio) begin
        exp_q.push_back(ref_gpio[d]);
        chk_rd = 1'b1;
      end else if (is_cnt) begin
        exp_q.push_back(ref_cyc[d] + 32'(ws));
        chk_rd = 1'b1;
      end else if (ref_known[d][a[9:0]]) begin
        exp_q.push_back(ref_ram[d][a[9:0]]);
        chk_rd = 1'b1;
      end
    end else begin
      if (is_gpio) begin
        gpio_after = wd;
      end else if (is_ram) begin
        ref_ram[d][a[9:0]]   = wd;
        ref_known[d][a[9:0]] = 1'b1;
      end
    end

    rd_i[d] = rd; wr_i[d] = wr; addr_i[d] = a; wd_i[d] = wd;
    tick();
    if (hold) begin
      rd_i[d] = 1'b1; wr_i[d] = 1'b0; addr_i[d] = GPIO_A; wd_i[d] = $urandom;
    end else begin
      rd_i[d] = 1'b0; wr_i[d] = 1'b0; addr_i[d] = $urandom; wd_i[d] = $urandom;
    end

    for (int k = 0; k <= ws; k++) begin
      if (k < ws) begin
        check($sformatf("%s_ready_early", tag), 32'(ready_o[d]), 32'd0);
        check($sformatf("%s_gpio_early", tag), gpio_o[d], gpio_before);
        tick();
      end else begin
        check($sformatf("%s_ready", tag), 32'(ready_o[d]), 32'd1);
        check($sformatf("%s_err", tag), 32'(err_o[d]), 32'(illegal));
        check($sformatf("%s_gpio", tag), gpio_o[d], gpio_after);
        if (chk_rd) check($sformatf("%s_rdata", tag), rdata_o[d], exp_q.pop_front());
      end
    end
    ref_gpio[d] = gpio_after;

    tick();
    rd_i[d] = 1'b0; wr_i[d] = 1'b0;
    check($sformatf("%s_ready_after", tag), 32'(ready_o[d]), 32'd0);
    if (hold) begin
      for (int q = 0; q < ws + 2; q++) begin
        tick();
        check($sformatf("%s_no_second", tag), 32'(ready_o[d]), 32'd0);
      end
    end
  endtask

  // Write to address 7 interrupted by reset while in WAIT.
  task automatic abort_test(input int d, input int extra);
    int ws;
    ws = ws_of(d);
    rd_i[d] = 1'b0; wr_i[d] = 1'b1; addr_i[d] = 32'd7; wd_i[d] = $urandom;
    tick();
    for (int q = 0; q < extra; q++) tick();
    check($sformatf("abort_%0d_in_wait", d), 32'(ready_o[d]), 32'd0);
    do_reset();
    for (int q = 0; q < ws + 3; q++) begin
      tick();
      check($sformatf("abort_%0d_no_ready", d), 32'(ready_o[d]), 32'd0);
    end
    check($sformatf("abort_%0d_gpio", d), gpio_o[d], 32'd0);
    do_req(d, 1'b1, 1'b0, 32'd7, 32'd0, 1'b0, $sformatf("abort_%0d_rd7", d));
  endtask

  // Preload the cycle counter just below the wrap point and read it repeatedly.
  task automatic wrap_test(input int d);
    case (d)
      0:       force u_ws1.cycle_cnt = 32'hFFFF_FFFE;
      1:       force u_ws0.cycle_cnt = 32'hFFFF_FFFE;
      default: force u_ws3.cycle_cnt = 32'hFFFF_FFFE;
    endcase
    #1;
    case (d)
      0:       release u_ws1.cycle_cnt;
      1:       release u_ws0.cycle_cnt;
      default: release u_ws3.cycle_cnt;
    endcase
    ref_cyc[d] = 32'hFFFF_FFFE;
    do_req(d, 1'b1, 1'b0, CNT_A, 32'd0, 1'b0, $sformatf("wrap_a_%0d", d));
    do_req(d, 1'b1, 1'b0, CNT_A, 32'd0, 1'b0, $sformatf("wrap_b_%0d", d));
    do_req(d, 1'b1, 1'b0, CNT_A, 32'd0, 1'b0, $sformatf("wrap_c_%0d", d));
  endtask

  task automatic random_req(input int d, input int n);
    logic        rd, wr;
    logic [31:0] a;
    int          r, k;
    bit          hold;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3, 4: a = 32'($urandom_range(0, 15));
      5:             a = 32'(DEPTH - 1);
      6:             a = GPIO_A;
      7:             a = CNT_A;
      8:             a = 32'(DEPTH + $urandom_range(0, 100));
      default:       a = $urandom;
    endcase
    k  = $urandom_range(0, 9);
    rd = (k == 0) || (k >= 5);
    wr = (k <= 4);
    hold = ($urandom_range(0, 3) == 0);
    do_req(d, rd, wr, a, $urandom, hold, $sformatf("rnd_%0d_%0d", d, n));
  endtask

  // Main sequence.
  initial begin
    clear_inputs();
    for (int d = 0; d < NDUT; d++) begin
      ref_cyc[d]  = '0;
      ref_gpio[d] = '0;
      for (int i = 0; i < DEPTH; i++) ref_known[d][i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    do_reset();

    // First request is taken on the first edge after release; counter starts at 0.
    do_req(1, 1'b1, 1'b0, CNT_A, 32'd0, 1'b0, "first_cnt");

    // Write then read back the same RAM word.
    do_req(0, 1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, "wr5");
    do_req(0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b0, "rd5");

    // GPIO write and readback.
    do_req(1, 1'b0, 1'b1, GPIO_A, 32'h0000_00A5, 1'b0, "gpio_wr");
    do_req(1, 1'b1, 1'b0, GPIO_A, 32'd0, 1'b0, "gpio_rd");

    // Illegal requests leave RAM and GPIO untouched.
    for (int d = 0; d < NDUT; d++) begin
      do_req(d, 1'b0, 1'b1, 32'd5, 32'h1111_0000 + 32'(d), 1'b0, $sformatf("ill_pre_%0d", d));
      do_req(d, 1'b0, 1'b1, GPIO_A, 32'h5A5A_0000 + 32'(d), 1'b0, $sformatf("ill_gp_%0d", d));
      do_req(d, 1'b1, 1'b0, 32'(DEPTH), 32'd0, 1'b0, $sformatf("ill_depth_%0d", d));
      do_req(d, 1'b0, 1'b1, CNT_A, 32'h1234_5678, 1'b0, $sformatf("ill_wrcnt_%0d", d));
      do_req(d, 1'b1, 1'b1, 32'd5, 32'hBAD0_BAD0, 1'b0, $sformatf("ill_both_%0d", d));
      do_req(d, 1'b1, 1'b1, GPIO_A, 32'hBAD1_BAD1, 1'b0, $sformatf("ill_bothgp_%0d", d));
      do_req(d, 1'b1, 1'b0, 32'd5, 32'd0, 1'b0, $sformatf("ill_post5_%0d", d));
      do_req(d, 1'b1, 1'b0, GPIO_A, 32'd0, 1'b0, $sformatf("ill_postgp_%0d", d));
      do_req(d, 1'b0, 1'b1, 32'(DEPTH - 1), 32'hC0DE_0000 + 32'(d), 1'b0, $sformatf("top_wr_%0d", d));
      do_req(d, 1'b1, 1'b0, 32'(DEPTH - 1), 32'd0, 1'b0, $sformatf("top_rd_%0d", d));
    end

    // A second request held through WAIT/RESP is ignored.
    do_req(2, 1'b0, 1'b1, 32'd9, 32'h0909_0909, 1'b1, "hold_ws3");
    do_req(0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1, "hold_ws1");
    do_req(2, 1'b1, 1'b0, 32'd9, 32'd0, 1'b0, "hold_ws3_rd");

    // Reset during WAIT aborts the write to address 7.
    do_req(0, 1'b0, 1'b1, 32'd7, 32'h7777_0000, 1'b0, "pre7_ws1");
    do_req(0, 1'b0, 1'b1, GPIO_A, 32'h0000_00FF, 1'b0, "pregp_ws1");
    abort_test(0, 0);
    do_req(2, 1'b0, 1'b1, 32'd7, 32'h7777_0002, 1'b0, "pre7_ws3");
    do_req(2, 1'b0, 1'b1, GPIO_A, 32'h0000_0F0F, 1'b0, "pregp_ws3");
    abort_test(2, 1);

    // Cycle counter wrap.
    for (int d = 0; d < NDUT; d++) wrap_test(d);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      for (int d = 0; d < NDUT; d++) random_req(d, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words in the data RAM (power of two, 16..65536).
REQ-002 Parameter WAIT_STATES, default 1, extra cycles inserted before each response (legal 0..7).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous assert, active-low (0 = reset).
REQ-005 read  input  1  CPU read request, sampled at rising clk.
REQ-006 write  input  1  CPU write request, sampled at rising clk.
REQ-007 address  input  32  word address (not byte address) of the request.
REQ-008 wdata  input  32  write data, driven by the CPU's dout.
REQ-009 rdata  output  32  read data, connected to the CPU's din.
REQ-010 ready  output  1  one-cycle pulse marking completion of the accepted request.
REQ-011 err  output  1  one-cycle pulse, coincident with ready, flagging an illegal request.
REQ-012 gpio_out  output  32  memory-mapped general-purpose output register.

Function
REQ-013 FSM states: IDLE, WAIT, RESP; exit from reset into IDLE.
REQ-014 In IDLE, read=1 or write=1 at a rising edge accepts the request; address, wdata and kind are captured; the FSM moves to WAIT when WAIT_STATES>0, else to RESP.
REQ-015 In WAIT, a 3-bit counter loaded with WAIT_STATES-1 decrements each cycle; at 0 the FSM moves to RESP.
REQ-016 RESP lasts exactly one cycle with ready=1; the FSM then returns to IDLE.
REQ-017 Latency: a request accepted at edge T yields ready high in cycle T+1+WAIT_STATES; minimum request spacing is 2+WAIT_STATES cycles.
REQ-018 Requests presented in WAIT or RESP are ignored, not queued; input changes after acceptance have no effect.
REQ-019 Address map: 0..DEPTH-1 RAM; 32'hFFFF_FF00 gpio_out (R/W); 32'hFFFF_FF04 cycle counter (read-only); all other addresses are illegal.
REQ-020 A RAM or gpio write is committed on the edge that enters RESP, never earlier.
REQ-021 Read data is captured on the edge that enters RESP; rdata holds that value until the next response.
REQ-022 Illegal cases (unmapped address, write to the counter, read=1 and write=1 together) assert err with ready, perform no write, and return rdata=0.
REQ-023 Cycle counter: 32-bit, increments every cycle, wraps from 32'hFFFF_FFFF to 0; a read returns the value at the capture edge.
REQ-024 Read-after-write to the same address in consecutive transactions returns the newly written data.
REQ-025 ready and err are 0 in all states other than RESP.

Reset
REQ-026 While rst=0: FSM=IDLE, ready=0, err=0, rdata=0, gpio_out=0, cycle counter=0, wait counter=0.
REQ-027 Reset asserted mid-transaction aborts it: no RAM or gpio write occurs and no ready pulse follows.
REQ-028 RAM contents are not cleared by reset.
REQ-029 The first request is accepted at the first rising edge after rst is released.

Verification
REQ-030 WAIT_STATES=1: write 32'hDEAD_BEEF to address 5, then read address 5 -> each ready appears 2 cycles after acceptance; read rdata=32'hDEAD_BEEF, err=0.
REQ-031 WAIT_STATES=0: write 32'h0000_00A5 to 32'hFFFF_FF00 -> gpio_out=32'hA5 from the ready edge; read back returns 32'hA5.
REQ-032 Read of address DEPTH (1024), write to 32'hFFFF_FF04, and read=write=1 -> each gives ready=1, err=1, rdata=0, RAM and gpio unchanged.
REQ-033 Second request held high during WAIT -> ignored; exactly one ready pulse is produced, and the request is accepted only if still present in IDLE.
REQ-034 Write to address 7 with rst pulsed low during WAIT -> no ready pulse; gpio_out=0; address 7 keeps its prior value.
REQ-035 Counter forced near 32'hFFFF_FFFE, then read across the wrap -> returned value is consistent with wrap to 0, err=0.
